// File: rtl/rb_arb_pkg.sv
// rb_arb_pkg: shared state encoding, grant ids and defaults for the register-bank arbiter
package rb_arb_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;
    localparam int DEFAULT_TIMEOUT = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;
endpackage

// File: rtl/toggle_sync.sv
// toggle_sync: multi-flop synchroniser for an incoming handshake toggle
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    // shift the toggle through the flop chain; cleared on reset
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
    assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: serialises decode reads and write-back writes onto one toggle-handshake bank port
module regbank_arbiter import rb_arb_pkg::*; #(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int AW          = 4,
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rdTriggerIn,
    input  logic [AW-1:0] rdAddrIn,
    output logic [DW-1:0] rdDataOut,
    output logic          rdReadyOut,
    input  logic          wrTriggerIn,
    input  logic [AW-1:0] wrAddrIn,
    input  logic [DW-1:0] wrDataIn,
    output logic          wrReadyOut,
    output logic          bankTriggerOut,
    output logic          bankWeOut,
    output logic [AW-1:0] bankAddrOut,
    output logic [DW-1:0] bankDataOut,
    input  logic          bankReadyIn,
    input  logic [DW-1:0] bankDataIn,
    output logic          timeoutErr
);
    localparam int TW = $clog2(TIMEOUT);

    logic          rd_sync, wr_sync, bank_sync;
    logic          rd_pend, wr_pend, bank_done, grant_d;
    state_t        state_q;
    logic          grant_q, rr_last_q;
    logic [TW-1:0] timer_q;
    logic [DW-1:0] rd_data_q, bank_data_q;
    logic [AW-1:0] bank_addr_q;
    logic          rd_ready_q, wr_ready_q, bank_trig_q, bank_we_q, timeout_q;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync   (.clk(clk), .reset(reset), .d_i(rdTriggerIn), .q_o(rd_sync));
    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync   (.clk(clk), .reset(reset), .d_i(wrTriggerIn), .q_o(wr_sync));
    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bank_sync (.clk(clk), .reset(reset), .d_i(bankReadyIn), .q_o(bank_sync));

    assign rd_pend   = rd_sync ^ rd_ready_q;
    assign wr_pend   = wr_sync ^ wr_ready_q;
    assign bank_done = bank_sync == bank_trig_q;

    // contention: same address lets the write go first, otherwise alternate against the last served side
    always_comb begin
        grant_d = (rd_pend && wr_pend) ? ((rdAddrIn == wrAddrIn) ? WR : ~rr_last_q) : (wr_pend ? WR : RD);
    end

    // access sequencer: grant in IDLE, await bank ack or timeout in WAIT, absorb a late ack in DRAIN
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= RD;
            rr_last_q   <= WR;
            timer_q     <= '0;
            rd_data_q   <= '0;
            rd_ready_q  <= 1'b0;
            wr_ready_q  <= 1'b0;
            bank_trig_q <= 1'b0;
            bank_we_q   <= 1'b0;
            bank_addr_q <= '0;
            bank_data_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (rd_pend || wr_pend) begin
                    grant_q     <= grant_d;
                    bank_we_q   <= grant_d;
                    bank_addr_q <= grant_d ? wrAddrIn : rdAddrIn;
                    bank_data_q <= wrDataIn;
                    bank_trig_q <= ~bank_trig_q;
                    timer_q     <= '0;
                    state_q     <= WAIT;
                end
                WAIT: if (bank_done) begin
                    if (grant_q == RD) rd_data_q <= bankDataIn;
                    rd_ready_q <= rd_ready_q ^ (grant_q == RD);
                    wr_ready_q <= wr_ready_q ^ (grant_q == WR);
                    rr_last_q  <= grant_q;
                    state_q    <= IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    if (grant_q == RD) rd_data_q <= '1;
                    rd_ready_q <= rd_ready_q ^ (grant_q == RD);
                    wr_ready_q <= wr_ready_q ^ (grant_q == WR);
                    timeout_q  <= 1'b1;
                    state_q    <= DRAIN;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
                DRAIN: if (bank_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdDataOut      = rd_data_q;
    assign rdReadyOut     = rd_ready_q;
    assign wrReadyOut     = wr_ready_q;
    assign bankTriggerOut = bank_trig_q;
    assign bankWeOut      = bank_we_q;
    assign bankAddrOut    = bank_addr_q;
    assign bankDataOut    = bank_data_q;
    assign timeoutErr     = timeout_q;
endmodule
